mux_mab_seq: RTL and testbench
==============================

Name: mux_mab_seq

Overview:
Parametrised, registered successor to the combinational memory-address-bus source mux. Selects one of NSRC address sources and registers it onto the MAB. Word-aligns the address in word mode and flags misalignment. Sequences multi-beat accesses, such as instruction extension words, by auto-incrementing the address under a valid/ready handshake with the memory model. Sits between the register file/address calculator and the memory model.

Parameters:
DW, 16, address width in bits
NSRC, 5, number of address sources on src_flat
SEL_W, 3, width of MAB_SEL; must satisfy 2^SEL_W >= NSRC
BEAT_W, 2, width of beat count; maximum burst length is 2^BEAT_W beats

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
src_flat  input  NSRC*DW  flattened sources; source i occupies bits [DW*(i+1)-1 : DW*i]
MAB_SEL  input  SEL_W  source select, sampled only on request acceptance
BW  input  1  1 = byte access, 0 = word access; sampled on acceptance
req  input  1  access request
burst_len  input  BEAT_W  beats minus one (0 = single beat); sampled on acceptance
mem_rdy  input  1  memory accepts the current beat
MAB_out  output  DW  registered memory address
MAB_valid  output  1  MAB_out holds a live beat
busy  output  1  high when the block cannot accept a request this cycle
done  output  1  one-cycle pulse on the final beat handshake
addr_err  output  1  one-cycle pulse: misaligned word address or illegal select

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; MAB_out=0; MAB_valid=0; busy=0; done=0; addr_err=0; beat counter=0; captured BW=0. Takes effect immediately, including mid-burst. The in-flight beat is dropped and no done pulse is produced.
- States: IDLE, BEAT.
- IDLE:
  - busy=0, MAB_valid=0.
  - On a clock edge with req=1 and MAB_SEL<NSRC, the request is accepted:
    - MAB_out <= src[MAB_SEL], with bit 0 forced to 0 when BW=0.
    - beats_left <= burst_len; BW is latched.
    - state <= BEAT.
  - Latency: accept edge to MAB_valid=1 is exactly one edge; the address is visible in the cycle after req.
- Misalignment: BW=0 and source bit 0 = 1 → addr_err pulses for one cycle, coincident with MAB_valid rising. The access proceeds with the aligned address.
- Illegal select: req=1 with MAB_SEL>=NSRC → request rejected, addr_err pulses next cycle, state remains IDLE, MAB_out unchanged.
- BEAT:
  - MAB_valid=1. busy=1, except on the final beat when mem_rdy=1.
  - While mem_rdy=0: MAB_out, beats_left and state are held stable. There is no timeout.
  - On mem_rdy=1 with beats_left>0: MAB_out <= MAB_out + (BW ? 1 : 2), modulo 2^DW (0xFFFE+2 wraps to 0x0000). beats_left decrements.
  - On mem_rdy=1 with beats_left=0: done pulses for that cycle (combinational on the handshake, registered outputs otherwise).
    - If req=1 in the same cycle with a legal select, the new request is accepted on that edge: back-to-back, no bubble, MAB_valid stays 1, MAB_out loads the new source.
    - Otherwise state <= IDLE and MAB_valid <= 0.
- req while busy=1 is ignored and not queued.
- src_flat or MAB_SEL changes during BEAT have no effect.
- Incrementer is DW bits wide; no carry output.

Test Plan:
- Reset then idle: src1=0x1234, no req → MAB_out=0x0000, MAB_valid=0, busy=0 for 5 cycles. Assert rst_n=0 asynchronously mid-cycle → outputs zero before the next edge.
- Single word access: MAB_SEL=1, src1=0xC000, BW=0, burst_len=0, mem_rdy=1 → MAB_out=0xC000 and MAB_valid=1 one cycle after req. done pulses in that cycle; next cycle MAB_valid=0.
- Stalled 3-beat word burst: src0=0xFFFC, burst_len=2, mem_rdy low for 2 cycles on beat 1 → addresses 0xFFFC (held 3 cycles), 0xFFFE, then 0x0000 (wrap); done on the 0x0000 handshake only.
- Byte burst and misalignment: BW=1, src2=0x0201, burst_len=1 → 0x0201, 0x0202, addr_err=0. Repeat with BW=0 → MAB_out=0x0200 and addr_err pulses once with MAB_valid rising.
- Illegal select and busy: MAB_SEL=6 (NSRC=5) → no MAB_valid, addr_err pulses once. During a 2-beat burst, a req on beat 0 is ignored (count beats=2). A req on the final handshake is accepted with MAB_valid continuous.
- Reset mid-burst: rst_n low during beat 2 of 4 → immediate MAB_valid=0, no done. After release, a new req behaves as in the single word access scenario.

Source files
------------

// File: rtl/mux_mab_seq_if.sv
// ============================================================================
// Module      : mux_mab_seq_if
// Description : Address-source/memory handshake bundle for mux_mab_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_mab_seq_if #(
    parameter int DW     = 16,
    parameter int NSRC   = 5,
    parameter int SEL_W  = 3,
    parameter int BEAT_W = 2
);
    logic [NSRC*DW-1:0] src_flat;
    logic [SEL_W-1:0]   MAB_SEL;
    logic               BW;
    logic               req;
    logic [BEAT_W-1:0]  burst_len;
    logic               mem_rdy;
    logic [DW-1:0]      MAB_out;
    logic               MAB_valid;
    logic               busy;
    logic               done;
    logic               addr_err;

    modport master (
        output src_flat, MAB_SEL, BW, req, burst_len, mem_rdy,
        input  MAB_out, MAB_valid, busy, done, addr_err
    );

    modport slave (
        input  src_flat, MAB_SEL, BW, req, burst_len, mem_rdy,
        output MAB_out, MAB_valid, busy, done, addr_err
    );
endinterface

`default_nettype wire

// File: rtl/mux_mab_seq.sv
// ============================================================================
// Module      : mux_mab_seq
// Description : Registered MAB source mux with word alignment and multi-beat
//               auto-increment sequencing under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_mab_seq #(
    parameter int DW     = 16,
    parameter int NSRC   = 5,
    parameter int SEL_W  = 3,
    parameter int BEAT_W = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux_mab_seq_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BEAT = 1'b1
    } state_t;

    localparam logic [SEL_W:0]    c_nsrc      = (SEL_W+1)'(NSRC);
    localparam logic [DW-1:0]     c_step_byte = DW'(1);
    localparam logic [DW-1:0]     c_step_word = DW'(2);
    localparam logic [BEAT_W-1:0] c_beat_one  = BEAT_W'(1);

    state_t             r_state;
    logic [DW-1:0]      r_mab;
    logic               r_valid;
    logic               r_addr_err;
    logic [BEAT_W-1:0]  r_beats_left;
    logic               r_bw;

    logic [DW-1:0]      w_src;
    logic [DW-1:0]      w_new_addr;
    logic               w_sel_ok;
    logic               w_last;
    logic               w_final_hs;
    logic               w_can_accept;
    logic               w_accept;

    always_comb begin
        w_src = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.MAB_SEL == i[SEL_W-1:0]) begin
                w_src = bus.src_flat[DW*i +: DW];
            end
        end
    end

    assign w_sel_ok     = {1'b0, bus.MAB_SEL} < c_nsrc;
    assign w_new_addr   = {w_src[DW-1:1], w_src[0] & bus.BW};
    assign w_last       = (r_beats_left == '0);
    assign w_final_hs   = (r_state == ST_BEAT) && bus.mem_rdy && w_last;
    // A new request may land in IDLE or on the very edge the last beat retires.
    assign w_can_accept = (r_state == ST_IDLE) || w_final_hs;
    assign w_accept     = w_can_accept && bus.req && w_sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mab        <= '0;
            r_valid      <= 1'b0;
            r_addr_err   <= 1'b0;
            r_beats_left <= '0;
            r_bw         <= 1'b0;
        end else begin
            r_addr_err <= w_can_accept && bus.req && !w_sel_ok;
            if (w_accept) begin
                r_state      <= ST_BEAT;
                r_mab        <= w_new_addr;
                r_valid      <= 1'b1;
                r_beats_left <= bus.burst_len;
                r_bw         <= bus.BW;
                r_addr_err   <= !bus.BW && w_src[0];
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_valid <= 1'b0;
                    end
                    ST_BEAT: begin
                        if (bus.mem_rdy) begin
                            if (!w_last) begin
                                r_mab        <= r_mab + (r_bw ? c_step_byte : c_step_word);
                                r_beats_left <= r_beats_left - c_beat_one;
                            end else begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.MAB_out   = r_mab;
    assign bus.MAB_valid = r_valid;
    assign bus.addr_err  = r_addr_err;
    assign bus.done      = w_final_hs;
    assign bus.busy      = (r_state == ST_BEAT) && !(bus.mem_rdy && w_last);

endmodule

`default_nettype wire

// File: tb/tb_mux_mab_seq.sv
// ============================================================================
// Module      : tb_mux_mab_seq
// Description : Directed self-checking bench for mux_mab_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_mab_seq;

    localparam int DW     = 16;
    localparam int NSRC   = 5;
    localparam int SEL_W  = 3;
    localparam int BEAT_W = 2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mux_mab_seq_if #(.DW(DW), .NSRC(NSRC), .SEL_W(SEL_W), .BEAT_W(BEAT_W)) bus ();

    mux_mab_seq #(.DW(DW), .NSRC(NSRC), .SEL_W(SEL_W), .BEAT_W(BEAT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int idx, input logic [DW-1:0] val);
        bus.src_flat[DW*idx +: DW] = val;
    endtask

    task automatic drive(input logic rq, input logic [SEL_W-1:0] sel, input logic bw,
                         input logic [BEAT_W-1:0] len, input logic rdy);
        bus.req       = rq;
        bus.MAB_SEL   = sel;
        bus.BW        = bw;
        bus.burst_len = len;
        bus.mem_rdy   = rdy;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic slot;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.src_flat = '0;
        drive(1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        set_src(1, 16'h1234);

        slot(); #1;
        chk("rst_mab",   {16'h0, bus.MAB_out}, 32'h0);
        chk("rst_valid", bus.MAB_valid, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_err",   bus.addr_err, 0);

        slot(); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            slot(); #1;
            chk("idle_mab",   {16'h0, bus.MAB_out}, 32'h0);
            chk("idle_valid", bus.MAB_valid, 0);
            chk("idle_busy",  bus.busy, 0);
        end

        // Single word access
        slot(); set_src(1, 16'hC000); drive(1'b1, 3'd1, 1'b0, 2'd0, 1'b1); #1;
        chk("sw_pre_valid", bus.MAB_valid, 0);
        chk("sw_pre_busy",  bus.busy, 0);
        slot(); bus.req = 1'b0; #1;
        chk("sw_mab",   {16'h0, bus.MAB_out}, 32'hC000);
        chk("sw_valid", bus.MAB_valid, 1);
        chk("sw_done",  bus.done, 1);
        chk("sw_busy",  bus.busy, 0);
        chk("sw_err",   bus.addr_err, 0);
        slot(); #1;
        chk("sw_post_valid", bus.MAB_valid, 0);
        chk("sw_post_done",  bus.done, 0);

        // Stalled 3-beat word burst with wrap
        slot(); set_src(0, 16'hFFFC); drive(1'b1, 3'd0, 1'b0, 2'd2, 1'b0);
        slot(); bus.req = 1'b0; #1;
        chk("st_b0a_mab",  {16'h0, bus.MAB_out}, 32'hFFFC);
        chk("st_b0a_busy", bus.busy, 1);
        chk("st_b0a_done", bus.done, 0);
        slot(); #1;
        chk("st_b0b_mab",  {16'h0, bus.MAB_out}, 32'hFFFC);
        slot(); bus.mem_rdy = 1'b1; #1;
        chk("st_b0c_mab",  {16'h0, bus.MAB_out}, 32'hFFFC);
        chk("st_b0c_done", bus.done, 0);
        chk("st_b0c_busy", bus.busy, 1);
        slot(); #1;
        chk("st_b1_mab",   {16'h0, bus.MAB_out}, 32'hFFFE);
        chk("st_b1_done",  bus.done, 0);
        slot(); #1;
        chk("st_b2_mab",   {16'h0, bus.MAB_out}, 32'h0000);
        chk("st_b2_valid", bus.MAB_valid, 1);
        chk("st_b2_done",  bus.done, 1);
        chk("st_b2_busy",  bus.busy, 0);
        slot(); #1;
        chk("st_end_valid", bus.MAB_valid, 0);

        // Byte burst, then the same source as a misaligned word burst
        slot(); set_src(2, 16'h0201); drive(1'b1, 3'd2, 1'b1, 2'd1, 1'b1);
        slot(); bus.req = 1'b0; #1;
        chk("by_b0_mab",  {16'h0, bus.MAB_out}, 32'h0201);
        chk("by_b0_err",  bus.addr_err, 0);
        chk("by_b0_done", bus.done, 0);
        slot(); #1;
        chk("by_b1_mab",  {16'h0, bus.MAB_out}, 32'h0202);
        chk("by_b1_done", bus.done, 1);
        chk("by_b1_err",  bus.addr_err, 0);
        slot(); drive(1'b1, 3'd2, 1'b0, 2'd1, 1'b1); #1;
        chk("ma_pre_valid", bus.MAB_valid, 0);
        slot(); bus.req = 1'b0; #1;
        chk("ma_b0_mab",   {16'h0, bus.MAB_out}, 32'h0200);
        chk("ma_b0_valid", bus.MAB_valid, 1);
        chk("ma_b0_err",   bus.addr_err, 1);
        slot(); #1;
        chk("ma_b1_mab",  {16'h0, bus.MAB_out}, 32'h0202);
        chk("ma_b1_err",  bus.addr_err, 0);
        chk("ma_b1_done", bus.done, 1);

        // Illegal select
        slot(); drive(1'b1, 3'd6, 1'b0, 2'd0, 1'b1);
        slot(); bus.req = 1'b0; #1;
        chk("il_valid", bus.MAB_valid, 0);
        chk("il_err",   bus.addr_err, 1);
        chk("il_mab",   {16'h0, bus.MAB_out}, 32'h0202);
        slot(); #1;
        chk("il_err_off", bus.addr_err, 0);
        chk("il_valid2",  bus.MAB_valid, 0);

        // 2-beat burst: req on beat 0 ignored, req on final handshake chained
        slot(); set_src(3, 16'h4000); set_src(4, 16'h5000); drive(1'b1, 3'd3, 1'b0, 2'd1, 1'b1);
        slot(); drive(1'b1, 3'd4, 1'b0, 2'd0, 1'b1); #1;
        chk("bz_b0_mab",  {16'h0, bus.MAB_out}, 32'h4000);
        chk("bz_b0_busy", bus.busy, 1);
        slot(); #1;
        chk("bz_b1_mab",  {16'h0, bus.MAB_out}, 32'h4002);
        chk("bz_b1_done", bus.done, 1);
        chk("bz_b1_busy", bus.busy, 0);
        slot(); bus.req = 1'b0; #1;
        chk("bb_mab",   {16'h0, bus.MAB_out}, 32'h5000);
        chk("bb_valid", bus.MAB_valid, 1);
        chk("bb_done",  bus.done, 1);
        slot(); #1;
        chk("bb_end_valid", bus.MAB_valid, 0);

        // Asynchronous reset during beat 2 of a 4-beat burst
        slot(); set_src(1, 16'h1000); drive(1'b1, 3'd1, 1'b0, 2'd3, 1'b1);
        slot(); bus.req = 1'b0; #1;
        chk("rb_b0_mab", {16'h0, bus.MAB_out}, 32'h1000);
        slot(); #1;
        chk("rb_b1_mab", {16'h0, bus.MAB_out}, 32'h1002);
        #1 rst_n = 1'b0;
        #1;
        chk("rb_valid", bus.MAB_valid, 0);
        chk("rb_mab",   {16'h0, bus.MAB_out}, 32'h0);
        chk("rb_done",  bus.done, 0);
        chk("rb_busy",  bus.busy, 0);
        slot(); rst_n = 1'b1;
        slot(); set_src(1, 16'hC000); drive(1'b1, 3'd1, 1'b0, 2'd0, 1'b1); #1;
        chk("rs_pre_valid", bus.MAB_valid, 0);
        slot(); bus.req = 1'b0; #1;
        chk("rs_mab",   {16'h0, bus.MAB_out}, 32'hC000);
        chk("rs_valid", bus.MAB_valid, 1);
        chk("rs_done",  bus.done, 1);
        slot(); #1;
        chk("rs_post_valid", bus.MAB_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
